// File: rtl/fp_addsub_pkg.sv
// Shared constants, state encoding and significand helpers for the
// single-precision add/sub scheduler.
package fp_addsub_pkg;

    localparam int FP_WIDTH  = 32;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;

    localparam int SIGN_POS = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX   = 8'd255;
    localparam logic [4:0]  ALIGN_MAX = 5'd26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // [27] carry, [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky
    typedef logic [27:0] wsig_t;

    function automatic wsig_t sig_of(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == 8'd0) ? '0 : {2'b01, x[MANT_MSB:MANT_LSB], 3'b000};
    endfunction

    function automatic wsig_t shr_sticky(input wsig_t s);
        return {1'b0, s[27:2], s[1] | s[0]};
    endfunction

endpackage

// File: rtl/fp_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant resets to 1 so requester 0 wins
// the first contested grant.
module fp_rr_arbiter2 (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/fp_addsub_scheduler.sv
// Shares one iterative IEEE-754 single add/sub datapath between two
// requesters with valid/ready handshakes on both sides.
//
//   state   | meaning
//   IDLE    | arbitrate, latch operands of the granted requester
//   COMPARE | order by magnitude, build significands, catch inf/NaN
//   ALIGN   | shift small significand right one bit per cycle
//   ADD     | add or subtract significands
//   NORM    | shift result one bit per cycle until leading bit is set
//   ROUND   | round to nearest even, pack result word
//   DONE    | hold result until consumer accepts it
module fp_addsub_scheduler
    import fp_addsub_pkg::*;
#(
    parameter int DATA_WIDTH = FP_WIDTH,
    parameter int MENT_WIDTH = FP_MANT_W,
    parameter int EXPO_WIDTH = FP_EXP_W
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [DATA_WIDTH-1:0] req0_a_in,
    input  logic [DATA_WIDTH-1:0] req0_b_in,
    input  logic                  req0_opcode_in,
    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [DATA_WIDTH-1:0] req1_a_in,
    input  logic [DATA_WIDTH-1:0] req1_b_in,
    input  logic                  req1_opcode_in,
    output logic                  result_valid_out,
    input  logic                  result_ready_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  result_id_out,
    output logic                  busy_out
);

    state_t state, state_nx;

    logic [1:0]            gnt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op_a, op_b, b_pick;
    logic                  opc_pick;
    logic                  op_id;

    wsig_t      sig_big, sig_small;
    logic [4:0] diff;
    logic [9:0] exp_w;
    logic       sign_w, eff_sub;
    logic [DATA_WIDTH-1:0] result_q;

    fp_rr_arbiter2 u_arb (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .valid    ({req1_valid_in, req0_valid_in}),
        .advance  (accept),
        .grant    (gnt)
    );

    assign b_pick   = gnt[1] ? req1_b_in : req0_b_in;
    assign opc_pick = gnt[1] ? req1_opcode_in : req0_opcode_in;

    logic [EXPO_WIDTH-1:0] exp_a, exp_b;
    logic [MENT_WIDTH-1:0] mant_a, mant_b;
    logic                  a_nan, b_nan, a_inf, b_inf, special;
    logic [DATA_WIDTH-1:0] special_val, op_big, op_small;
    logic                  a_is_big;
    logic [7:0]            exp_gap;
    logic [4:0]            diff_cmp;

    assign exp_a   = op_a[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign exp_b   = op_b[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign mant_a  = op_a[MENT_WIDTH-1:0];
    assign mant_b  = op_b[MENT_WIDTH-1:0];
    assign a_nan   = (exp_a == EXP_MAX) && (mant_a != '0);
    assign b_nan   = (exp_b == EXP_MAX) && (mant_b != '0);
    assign a_inf   = (exp_a == EXP_MAX) && (mant_a == '0);
    assign b_inf   = (exp_b == EXP_MAX) && (mant_b == '0);
    assign special = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_inf && (op_a[SIGN_POS] != op_b[SIGN_POS]))) begin
            special_val = QNAN;
        end else if (a_inf) begin
            special_val = {op_a[SIGN_POS], EXP_MAX, {MENT_WIDTH{1'b0}}};
        end else begin
            special_val = {op_b[SIGN_POS], EXP_MAX, {MENT_WIDTH{1'b0}}};
        end
    end

    // Magnitude order on {exp,mant}; op_b already carries the effective sign.
    assign a_is_big = op_a[EXP_MSB:0] >= op_b[EXP_MSB:0];
    assign op_big   = a_is_big ? op_a : op_b;
    assign op_small = a_is_big ? op_b : op_a;
    assign exp_gap  = op_big[EXP_MSB:EXP_LSB] - op_small[EXP_MSB:EXP_LSB];
    assign diff_cmp = (exp_gap > 8'd26) ? ALIGN_MAX : exp_gap[4:0];

    wsig_t add_res;
    logic  need_norm;

    assign add_res   = eff_sub ? (sig_big - sig_small) : (sig_big + sig_small);
    assign need_norm = add_res[27] | (~add_res[26] & (exp_w > 10'd1));

    wsig_t      norm_sig;
    logic [9:0] norm_exp;
    logic       norm_more;

    always_comb begin
        norm_sig = sig_big;
        norm_exp = exp_w;
        if (sig_big[27]) begin
            norm_sig = shr_sticky(sig_big);
            norm_exp = exp_w + 10'd1;
        end else if (!sig_big[26] && (exp_w > 10'd1)) begin
            norm_sig = {sig_big[26:0], 1'b0};
            norm_exp = exp_w - 10'd1;
        end
        norm_more = norm_sig[27] | (~norm_sig[26] & (norm_exp > 10'd1));
    end

    logic                  round_up;
    logic [24:0]           mant_r;
    logic [22:0]           frac_r;
    logic [9:0]            exp_r;
    logic [DATA_WIDTH-1:0] round_word;

    always_comb begin
        round_up = sig_big[2] & (sig_big[1] | sig_big[0] | sig_big[3]);
        mant_r   = {1'b0, sig_big[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            frac_r = mant_r[23:1];
            exp_r  = exp_w + 10'd1;
        end else begin
            frac_r = mant_r[22:0];
            exp_r  = exp_w;
        end
        // A clear leading bit here means the value sank below the normal range.
        if (!sig_big[26]) begin
            round_word = {sign_w, 31'd0};
        end else if (exp_r >= {2'b00, EXP_MAX}) begin
            round_word = {sign_w, EXP_MAX, 23'd0};
        end else begin
            round_word = {sign_w, exp_r[7:0], frac_r};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        req0_ready_out = 1'b0;
        req1_ready_out = 1'b0;
        accept         = 1'b0;
        case (state)
            S_IDLE: begin
                req0_ready_out = gnt[0];
                req1_ready_out = gnt[1];
                accept         = gnt[0] | gnt[1];
                if (accept) state_nx = S_COMPARE;
            end
            S_COMPARE: begin
                if (special)               state_nx = S_DONE;
                else if (exp_gap == 8'd0)  state_nx = S_ADD;
                else                       state_nx = S_ALIGN;
            end
            S_ALIGN: begin
                if (diff == 5'd1) state_nx = S_ADD;
            end
            S_ADD: begin
                if (add_res == '0)  state_nx = S_DONE;
                else if (need_norm) state_nx = S_NORM;
                else                state_nx = S_ROUND;
            end
            S_NORM: begin
                if (!norm_more) state_nx = S_ROUND;
            end
            S_ROUND: state_nx = S_DONE;
            S_DONE: begin
                if (result_ready_in) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            sig_big   <= '0;
            sig_small <= '0;
            diff      <= '0;
            exp_w     <= '0;
            sign_w    <= 1'b0;
            eff_sub   <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a  <= gnt[1] ? req1_a_in : req0_a_in;
                        op_b  <= {b_pick[SIGN_POS] ^ opc_pick, b_pick[SIGN_POS-1:0]};
                        op_id <= gnt[1];
                    end
                end
                S_COMPARE: begin
                    if (special) begin
                        result_q <= special_val;
                    end else begin
                        sig_big   <= sig_of(op_big);
                        sig_small <= sig_of(op_small);
                        diff      <= diff_cmp;
                        exp_w     <= {2'b00, op_big[EXP_MSB:EXP_LSB]};
                        sign_w    <= op_big[SIGN_POS];
                        eff_sub   <= op_big[SIGN_POS] ^ op_small[SIGN_POS];
                    end
                end
                S_ALIGN: begin
                    sig_small <= shr_sticky(sig_small);
                    diff      <= diff - 5'd1;
                end
                S_ADD: begin
                    sig_big <= add_res;
                    if (add_res == '0) result_q <= '0;
                end
                S_NORM: begin
                    sig_big <= norm_sig;
                    exp_w   <= norm_exp;
                end
                S_ROUND: result_q <= round_word;
                default: ;
            endcase
        end
    end

    assign result_valid_out = (state == S_DONE);
    assign result_out       = result_q;
    assign result_id_out    = op_id;
    assign busy_out         = (state != S_IDLE);

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Self-checking bench: vector table with scoreboard, plus reset-abort and
// round-robin alternation sequences.
module tb_fp_addsub_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_id, busy;
    logic [31:0] res;

    always #5 clk = ~clk;

    fp_addsub_scheduler dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .req0_valid_in    (req0_valid),
        .req0_ready_out   (req0_ready),
        .req0_a_in        (req0_a),
        .req0_b_in        (req0_b),
        .req0_opcode_in   (req0_op),
        .req1_valid_in    (req1_valid),
        .req1_ready_out   (req1_ready),
        .req1_a_in        (req1_a),
        .req1_b_in        (req1_b),
        .req1_opcode_in   (req1_op),
        .result_valid_out (res_valid),
        .result_ready_in  (res_ready),
        .result_out       (res),
        .result_id_out    (res_id),
        .busy_out         (busy)
    );

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        id;
    } exp_t;

    vec_t vecs[13];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic op);
        if (port == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got result %h with nothing expected", res);
        end else begin
            e = sb_q.pop_front();
            check("result", res, e.res);
            check("result_id", {31'd0, res_id}, {31'd0, e.id});
        end
    endtask

    task automatic wait_valid(inout int edges);
        while (res_valid !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int edges;
        @(negedge clk);
        set_req(v.port, 1'b1, v.a, v.b, v.op);
        sb_q.push_back('{res: v.res, id: (v.port == 1)});
        #1;
        check("accept_ready", {31'd0, (v.port == 0) ? req0_ready : req1_ready}, 32'd1);
        @(posedge clk);
        edges = 1;
        #1;
        set_req(v.port, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_valid(edges);
        check("latency", 32'(edges), 32'(v.lat));
        pop_and_check();
        if (v.hold > 0) begin
            set_req(0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
            set_req(1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_result", res, v.res);
                check("hold_valid", {31'd0, res_valid}, 32'd1);
                check("hold_busy", {31'd0, busy}, 32'd1);
                check("hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            end
            set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
            set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("valid_cleared", {31'd0, res_valid}, 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e;
        int   w;
        logic model_last;
        int   exp_g;

        //        port a              b              op    result         lat hold
        vecs[0]  = '{0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000,  5, 0};
        vecs[1]  = '{1, 32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000,  6, 3};
        vecs[2]  = '{0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 28, 0};
        vecs[3]  = '{1, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 28, 0};
        vecs[4]  = '{0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000,  3, 0};
        vecs[5]  = '{1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000,  2, 0};
        vecs[6]  = '{0, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000,  6, 0};
        vecs[7]  = '{1, 32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000,  6, 0};
        vecs[8]  = '{0, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000,  2, 0};
        vecs[9]  = '{1, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000,  2, 0};
        vecs[10] = '{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000,  5, 0};
        vecs[11] = '{1, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 28, 0};
        vecs[12] = '{0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 30, 0};

        rst_n = 1'b0;
        res_ready = 1'b0;
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", res, 32'd0);
        check("rst_id", {31'd0, res_id}, 32'd0);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i]);
        end

        // Abort an operation in the middle of alignment.
        @(negedge clk);
        set_req(0, 1'b1, 32'h3F800000, 32'h33800000, 1'b0);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("align_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, res_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters valid continuously: grants must alternate from req0.
        model_last = 1'b1;
        set_req(0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
        set_req(1, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            w = 0;
            #1;
            while (!(req0_ready | req1_ready) && w < 50) begin
                @(negedge clk);
                #1;
                w++;
            end
            exp_g = model_last ? 0 : 1;
            check("rr_grant", {30'd0, req1_ready, req0_ready}, (exp_g == 0) ? 32'd1 : 32'd2);
            sb_q.push_back('{res: (exp_g == 0) ? 32'h40000000 : 32'h40800000, id: (exp_g == 1)});
            model_last = (exp_g == 1);
            @(posedge clk);
            e = 1;
            #1;
            wait_valid(e);
            check("rr_valid", {31'd0, res_valid}, 32'd1);
            pop_and_check();
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_addsub_scheduler.md
Name: fp_addsub_scheduler

Overview:
- Multi-cycle sequencer that shares one IEEE-754 single-precision add/subtract datapath between two requesters.
- Stages run in order: round-robin arbitration, exponent compare and swap, iterative mantissa alignment, mantissa add/sub, iterative normalization, then round-to-nearest-even.
- Sits between the issue logic and the result writeback of the FPU.
- Uses valid/ready handshakes on both requester ports and on the result port.

Parameters:
- DATA_WIDTH, 32, floating-point word width.
- MENT_WIDTH, 23, stored mantissa bits.
- EXPO_WIDTH, 8, exponent bits.

Ports:
- clk_in, input, 1, single clock; all state updates on the rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- req0_valid_in, input, 1, requester 0 has an operation.
- req0_ready_out, output, 1, requester 0 is accepted this cycle.
- req0_a_in, input, 32, requester 0 operand A.
- req0_b_in, input, 32, requester 0 operand B.
- req0_opcode_in, input, 1, requester 0 operation: 0 = A+B, 1 = A-B.
- req1_valid_in / req1_ready_out / req1_a_in / req1_b_in / req1_opcode_in: same as requester 0, for requester 1.
- result_valid_out, output, 1, result available.
- result_ready_in, input, 1, consumer accepts the result.
- result_out, output, 32, result word.
- result_id_out, output, 1, index of the requester that owns the result.
- busy_out, output, 1, high in every state except IDLE.

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE; all outputs 0; last_grant=1, so requester 0 wins first.
  - Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, COMPARE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE:
  - reqX_ready_out = reqX_valid_in & granted (combinational, asserted only in IDLE).
  - Grant goes to the single valid requester. If both are valid, the grant goes to the one not equal to last_grant.
  - On the accepting edge: latch operands, effective sign of B (B sign XOR opcode) and the id; update last_grant; go to COMPARE.
- COMPARE (1 cycle):
  - Order operands by magnitude {exp,mant}; the larger becomes big.
  - Load diff = exp_big - exp_small, clamped to 26.
  - Form 24-bit significands with the hidden bit set (exp 0 is treated as zero: significand 0, exp treated as 0).
  - Append 3 zero bits as guard/round/sticky.
  - Special cases jump directly to DONE:
    - either exp = 255: NaN input or inf-inf gives 0x7FC00000; otherwise signed infinity.
  - If diff = 0, go to ADD; otherwise go to ALIGN.
- ALIGN:
  - Each cycle: shift the small significand right 1 bit, OR the shifted-out bit into sticky, decrement diff.
  - Exit to ADD when diff reaches 0. Takes n = min(diff, 26) cycles.
- ADD (1 cycle):
  - Same effective signs: 28-bit sum. Otherwise: big - small.
  - Result sign = sign of big.
  - Zero magnitude gives +0 (0x00000000) and goes to DONE.
  - Otherwise go to NORM.
- NORM, m cycles:
  - Carry-out set: shift right 1 (sticky accumulates), exp+1, 1 cycle.
  - Else while MSB is clear and exp > 1: shift left 1, exp-1, 1 bit per cycle.
  - m = 0 if already normalized.
- ROUND (1 cycle):
  - Round to nearest even on guard/round/sticky.
  - Mantissa overflow after rounding renormalizes and increments exp.
  - exp >= 255 gives signed infinity.
  - A leading bit still clear at exp 1 flushes to signed zero.
- DONE:
  - result_valid_out=1; result_out and result_id_out held stable until result_ready_in=1.
  - On the handshake edge: go to IDLE and clear result_valid_out.
  - No new request is accepted in the same cycle.
- Latency: result_valid_out rises 4 + n + m rising edges after the accepting edge. Special cases take 2 edges.
- Throughput: one operation in flight at a time.

Decomposition:
- Package fp_addsub_pkg holds:
  - the width constants;
  - field-slice localparams (sign, exp and mantissa positions);
  - QNAN = 32'h7FC00000 and EXP_MAX = 255;
  - the state enum;
  - the 28-bit working significand typedef.
- Sub-module fp_rr_arbiter2 implements the 2-way round-robin arbiter with its last_grant flop.
- The FSM, shift counters and rounding logic stay in the top module.

Test Plan:
- req0: 0x3F800000 + 0x3F800000, opcode 0 -> result 0x40000000, id 0, valid 5 edges after accept (carry NORM, m=1).
- req1: 0x3FC00000 + 0x3E800000 -> 0x3FE00000, diff 2, valid 6 edges after accept; hold result_ready_in=0 for 3 cycles -> output stable, busy_out=1, requesters not ready.
- 0x3F800000 + 0x33800000 -> 0x3F800000 (tie rounds to even); 0x3F800000 + 0x33C00000 -> 0x3F800001; alignment takes 24 cycles.
- 0x3F800000 - 0x3F800000 (opcode 1) -> 0x00000000; 0x7F800000 - 0x7F800000 -> 0x7FC00000 after 2 edges.
- Both requesters valid continuously, 4 ops -> grants alternate 0,1,0,1 starting with 0 after reset; result_id_out matches each grant.
- Drop rst_n_in during ALIGN -> immediately result_valid_out=0, busy_out=0; after release, next grant goes to req0.
